// File: rtl/exec_stage_if.sv
// Execute-stage bus: upstream operand handshake plus downstream result handshake.
// master = producer of operands / consumer of results, slave = exec_stage.
interface exec_stage_if #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 6,
  parameter int OPW    = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OPW-1:0]    alu_op;
  logic [DWIDTH-1:0] opA;
  logic [DWIDTH-1:0] opB;
  logic [DWIDTH-1:0] opBwd;
  logic [RWIDTH-1:0] wa_in;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] result;
  logic [DWIDTH-1:0] st_data;
  logic [RWIDTH-1:0] wa_out;
  logic              zero;
  logic              ovf;
  logic              ill_op;

  modport master (
    output in_valid, alu_op, opA, opB, opBwd, wa_in, out_ready,
    input  in_ready, out_valid, result, st_data, wa_out, zero, ovf, ill_op
  );

  modport slave (
    input  in_valid, alu_op, opA, opB, opBwd, wa_in, out_ready,
    output in_ready, out_valid, result, st_data, wa_out, zero, ovf, ill_op
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU or iterative shift-add multiply feeding a
// valid/ready output register. Optional multiplier is enabled by defining
// EXEC_MUL_EN; without it opcode 9 is treated as illegal with latency 1.
module exec_stage #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 6,
  parameter int OPW    = 4
) (
  input logic        clk,
  input logic        rst_n,
  exec_stage_if.slave bus
);
  localparam int SHW = $clog2(DWIDTH);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA = OPW'(7);
  localparam logic [OPW-1:0] OP_SLT = OPW'(8);

  logic              out_valid_q;
  logic [DWIDTH-1:0] result_q;
  logic [DWIDTH-1:0] st_data_q;
  logic [RWIDTH-1:0] wa_out_q;
  logic              zero_q;
  logic              ovf_q;
  logic              ill_q;

  logic [DWIDTH-1:0] sum;
  logic [DWIDTH-1:0] diff;
  logic [DWIDTH-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;
  logic [SHW-1:0]    shamt;
  logic              in_ready;
  logic              alu_load;
  logic              out_xfer;

  assign sum      = bus.opA + bus.opB;
  assign diff     = bus.opA - bus.opB;
  assign shamt    = bus.opB[SHW-1:0];
  assign out_xfer = out_valid_q & bus.out_ready;

  // Single-cycle ALU; anything not decoded here (including MUL) is flagged illegal,
  // but MUL never takes this path when the multiplier is present.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.opA[DWIDTH-1] == bus.opB[DWIDTH-1]) && (sum[DWIDTH-1] != bus.opA[DWIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.opA[DWIDTH-1] != bus.opB[DWIDTH-1]) && (diff[DWIDTH-1] != bus.opA[DWIDTH-1]);
      end
      OP_AND:  alu_res = bus.opA & bus.opB;
      OP_OR:   alu_res = bus.opA | bus.opB;
      OP_XOR:  alu_res = bus.opA ^ bus.opB;
      OP_SLL:  alu_res = bus.opA << shamt;
      OP_SRL:  alu_res = bus.opA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.opA) >>> shamt);
      OP_SLT:  alu_res = {{(DWIDTH-1){1'b0}}, ($signed(bus.opA) < $signed(bus.opB))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = OPW'(9);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state, state_nxt;

  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] mcand;
  logic [DWIDTH-1:0] mplier;
  logic [DWIDTH-1:0] step_acc;
  logic [DWIDTH-1:0] mul_res;
  logic [DWIDTH-1:0] mst_data;
  logic [RWIDTH-1:0] mwa;
  logic [SHW-1:0]    cnt;
  logic              last;
  logic              start_mul;
  logic              mul_load;

  assign step_acc = acc + (mplier[0] ? mcand : '0);
  assign last     = (cnt == SHW'(DWIDTH - 1));
  // HOLD parks the finished product in acc; in MUL the last step feeds the register directly.
  assign mul_res  = (state == HOLD) ? acc : step_acc;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, input handshake and output-register load strobes
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start_mul = 1'b0;
    alu_load  = 1'b0;
    mul_load  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n & (~out_valid_q | bus.out_ready);
        if (bus.in_valid && in_ready) begin
          if (bus.alu_op == OP_MUL) begin
            start_mul = 1'b1;
            state_nxt = MUL;
          end else begin
            alu_load = 1'b1;
          end
        end
      end
      MUL: begin
        if (last) begin
          if (!out_valid_q || bus.out_ready) begin
            mul_load  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          mul_load  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath: one partial product per cycle, LSB of multiplier first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      mst_data <= '0;
      mwa      <= '0;
    end else if (start_mul) begin
      acc      <= '0;
      mcand    <= bus.opA;
      mplier   <= bus.opB;
      cnt      <= '0;
      mst_data <= bus.opBwd;
      mwa      <= bus.wa_in;
    end else if (state == MUL) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
    end
  end
`else
  assign in_ready = rst_n & (~out_valid_q | bus.out_ready);
  assign alu_load = bus.in_valid & in_ready;
`endif

  // Output register: loads a new result (possibly while the old one transfers),
  // otherwise holds everything and only drops valid on transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      st_data_q   <= '0;
      wa_out_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else if (alu_load) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      st_data_q   <= bus.opBwd;
      wa_out_q    <= bus.wa_in;
      zero_q      <= (alu_res == '0);
      ovf_q       <= alu_ovf;
      ill_q       <= alu_ill;
`ifdef EXEC_MUL_EN
    end else if (mul_load) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_res;
      st_data_q   <= mst_data;
      wa_out_q    <= mwa;
      zero_q      <= (mul_res == '0);
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
`endif
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.st_data   = st_data_q;
  assign bus.wa_out    = wa_out_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.ill_op    = ill_q;
endmodule
